load_store_ctrl: RTL and testbench
==================================

LOAD_STORE_CTRL -- requirements
Module: load_store_ctrl

Interface
REQ-001 Parameter WordSize, default 32, data and address width in bits.
REQ-002 Parameter RD_WAIT, default 2, cycles Mem_rd is held before read data is captured; legal range 1..15.
REQ-003 Parameter WR_WAIT, default 1, cycles Mem_wr is held; legal range 1..15.
REQ-004 CLK  input  1  single clock; all state changes on posedge.
REQ-005 RESET_N  input  1  asynchronous, active-low reset.
REQ-006 req  input  1  core access request, sampled at posedge.
REQ-007 wr  input  1  1 = store, 0 = load; sampled with req.
REQ-008 addr  input  WordSize  byte address of the access.
REQ-009 wdata  input  WordSize  store data.
REQ-010 busy  output  1  access in progress; request is not accepted while busy=1.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 err  output  1  valid with done; 1 = misaligned access, no memory access performed.
REQ-013 rdata  output  WordSize  load result; holds its value until the next completed load.
REQ-014 acc_count  output  16  count of completed aligned accesses; wraps.
REQ-015 Mem_Addr  output  WordSize  address to data memory.
REQ-016 Mem_rd  output  1  memory read enable.
REQ-017 Mem_wr  output  1  memory write enable; memory commits on negedge CLK.
REQ-018 Mem_DIN  output  WordSize  write data to memory.
REQ-019 Mem_DOUT  input  WordSize  read data from memory.

Function
REQ-020 The FSM SHALL have the states IDLE, READ, WRITE and DONE; all memory-side outputs SHALL be registered.
REQ-021 In IDLE, with req=1 and addr[1:0]=00: addr and wdata are latched; next state is WRITE if wr=1, else READ; wait counter (4 bits) loads WR_WAIT-1 or RD_WAIT-1.
REQ-022 In IDLE, with req=1 and addr[1:0]!=00: next state is DONE with err=1; Mem_rd and Mem_wr stay 0; acc_count is unchanged.
REQ-023 In READ, Mem_rd=1 and Mem_Addr=latched address; the counter decrements each cycle; at count 0, Mem_DOUT is captured into rdata and the next state is DONE.
REQ-024 In WRITE, Mem_wr=1 and Mem_DIN=latched wdata, held stable across every negedge within the state; at count 0 the next state is DONE.
REQ-025 In DONE, done=1 for exactly one cycle; err reflects that access; next state is IDLE; acc_count increments if err=0.
REQ-026 busy SHALL be 1 in READ, WRITE and DONE, and 0 only in IDLE; req in any non-IDLE state is ignored (not queued).
REQ-027 Mem_rd and Mem_wr SHALL never be 1 in the same cycle; both SHALL be 0 outside READ and WRITE.
REQ-028 Latency from the req-sampling edge to done high: RD_WAIT+1 cycles for a load, WR_WAIT+1 for a store, 1 for a misaligned access.
REQ-029 A back-to-back request is accepted no earlier than the first posedge after done falls (IDLE).
REQ-030 acc_count wraps from 16'hFFFF to 0 without any flag.

Reset
REQ-031 With RESET_N=0, the block SHALL immediately enter IDLE, with busy, done, err, Mem_rd and Mem_wr = 0, and rdata, acc_count, Mem_Addr and Mem_DIN = 0.
REQ-032 A reset during READ or WRITE SHALL abort the access; Mem_wr drops asynchronously, before the next negedge where possible; rdata is not updated.
REQ-033 After RESET_N rises, the first req is honoured at the first posedge.

Verification
REQ-034 Load: memory word[4]=32'hDEADBEEF, RD_WAIT=2; req=1, wr=0, addr=16 -> Mem_rd high for 2 cycles, done at cycle 3, rdata=32'hDEADBEEF, err=0, acc_count=1.
REQ-035 Store: req=1, wr=1, addr=8, wdata=32'h12345678, WR_WAIT=1 -> Mem_wr high 1 cycle, memory word[2]=32'h12345678, done at cycle 2, Mem_rd=0 throughout.
REQ-036 Misaligned: addr=6, wr=1 -> done and err high 1 cycle after the request, Mem_wr never asserted, acc_count unchanged.
REQ-037 Busy drop: req held high continuously while a load is in progress -> only one access is performed until IDLE; the second access starts the cycle after done.
REQ-038 Reset mid-write: RESET_N low during WRITE with WR_WAIT=3 -> Mem_wr=0 immediately, no done pulse, and a new load after reset returns correct data.
REQ-039 Wrap: preload acc_count to 16'hFFFF via 65535 accesses (or force), then one more access -> acc_count=0.

Source files
------------

// File: rtl/load_store_ctrl.sv
// ---------------------------------------------------------------------------
// load_store_ctrl
//
// Sequences single-word loads and stores from a core onto a simple
// synchronous data memory. Accepts one request at a time, stretches the
// memory enables for a parameterised number of wait cycles and reports
// completion with a one-cycle done pulse. Misaligned addresses never touch
// memory; they complete immediately with err set.
//
// Parameters
//   WordSize  data / address width in bits
//   RD_WAIT   cycles Mem_rd is held before read data is captured (1..15)
//   WR_WAIT   cycles Mem_wr is held (1..15)
//
// Ports
//   CLK, RESET_N          clock, asynchronous active-low reset
//   req, wr, addr, wdata  core request (wr=1 store, wr=0 load)
//   busy, done, err       handshake / completion status
//   rdata                 last completed load result
//   acc_count             completed aligned accesses (wraps)
//   Mem_Addr, Mem_rd, Mem_wr, Mem_DIN, Mem_DOUT   data memory interface
// ---------------------------------------------------------------------------
module load_store_ctrl #(
    parameter int WordSize = 32,
    parameter int RD_WAIT  = 2,
    parameter int WR_WAIT  = 1
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                req,
    input  logic                wr,
    input  logic [WordSize-1:0] addr,
    input  logic [WordSize-1:0] wdata,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [WordSize-1:0] rdata,
    output logic [15:0]         acc_count,
    output logic [WordSize-1:0] Mem_Addr,
    output logic                Mem_rd,
    output logic                Mem_wr,
    output logic [WordSize-1:0] Mem_DIN,
    input  logic [WordSize-1:0] Mem_DOUT
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    // The wait counter is loaded with WAIT-1 so that the enable stays high
    // for exactly WAIT cycles, counting down to zero.
    localparam logic [3:0] RdLoad = 4'(RD_WAIT - 1);
    localparam logic [3:0] WrLoad = 4'(WR_WAIT - 1);

    state_t      state;
    state_t      next_state;
    logic [3:0]  wait_cnt;
    logic        err_q;
    logic [15:0] acc_count_q;
    logic        misaligned;
    logic        count_zero;
    logic        mem_rd_next;
    logic        mem_wr_next;

    assign misaligned = |addr[1:0];
    assign count_zero = (wait_cnt == 4'd0);
    assign acc_count  = acc_count_q;

    // State register.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. Requests are only looked at in IDLE; anything that
    // arrives while busy is simply dropped.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (misaligned) begin
                        next_state = DONE;
                    end else if (wr) begin
                        next_state = WRITE;
                    end else begin
                        next_state = READ;
                    end
                end
            end
            READ: begin
                if (count_zero) begin
                    next_state = DONE;
                end
            end
            WRITE: begin
                if (count_zero) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // Output decode. The memory enables are derived from next_state and
    // then registered, so they line up exactly with the READ/WRITE states
    // while still coming straight out of flops.
    always_comb begin
        busy        = (state != IDLE);
        done        = (state == DONE);
        err         = (state == DONE) && err_q;
        mem_rd_next = (next_state == READ);
        mem_wr_next = (next_state == WRITE);
    end

    // Datapath: request latching, wait counting, load capture and the
    // access counter. Mem_wr sits on the asynchronous reset so an aborted
    // store stops driving memory without waiting for a clock edge.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            Mem_rd      <= 1'b0;
            Mem_wr      <= 1'b0;
            Mem_Addr    <= '0;
            Mem_DIN     <= '0;
            rdata       <= '0;
            wait_cnt    <= 4'd0;
            err_q       <= 1'b0;
            acc_count_q <= 16'd0;
        end else begin
            Mem_rd <= mem_rd_next;
            Mem_wr <= mem_wr_next;
            case (state)
                IDLE: begin
                    if (req) begin
                        err_q <= misaligned;
                        if (!misaligned) begin
                            Mem_Addr <= addr;
                            Mem_DIN  <= wdata;
                            wait_cnt <= wr ? WrLoad : RdLoad;
                        end
                    end
                end
                READ: begin
                    if (count_zero) begin
                        rdata <= Mem_DOUT;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                WRITE: begin
                    if (!count_zero) begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                DONE: begin
                    if (!err_q) begin
                        acc_count_q <= acc_count_q + 16'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_ctrl.sv
// ---------------------------------------------------------------------------
// tb_load_store_ctrl
//
// Directed bench for load_store_ctrl. The main instance uses the default
// wait settings; a second instance with WR_WAIT=3 is held in reset except
// for the mid-write abort sequence. Each instance has a small word memory
// that commits writes on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_load_store_ctrl;

    logic        CLK;
    logic        RESET_N;
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        err;
    logic [31:0] rdata;
    logic [15:0] acc_count;
    logic [31:0] Mem_Addr;
    logic        Mem_rd;
    logic        Mem_wr;
    logic [31:0] Mem_DIN;
    logic [31:0] Mem_DOUT;

    logic        rst_b;
    logic        req_b;
    logic        busy_b;
    logic        done_b;
    logic        err_b;
    logic [31:0] rdata_b;
    logic [15:0] acc_b;
    logic [31:0] mem_addr_b;
    logic        mem_rd_b;
    logic        mem_wr_b;
    logic [31:0] mem_din_b;
    logic [31:0] mem_dout_b;

    logic        mem_load;
    logic [31:0] mem_a [64];
    logic [31:0] mem_b [64];

    // Observation view of whichever instance the current transaction uses.
    logic        sel;
    logic        o_busy;
    logic        o_done;
    logic        o_err;
    logic        o_rd;
    logic        o_wr;
    logic [31:0] o_rdata;
    logic [15:0] o_acc;

    int total;
    int bad;

    int          r_lat;
    logic        r_err;
    logic [31:0] r_rdata;
    int          r_rd;
    int          r_wr;
    int          r_overlap;
    logic        r_done_after;
    logic        r_busy_after;
    logic [15:0] r_acc;

    typedef struct {
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic        e_err;
        logic [31:0] e_rdata;
        int          e_lat;
        int          e_rd;
        int          e_wr;
        logic [15:0] e_acc;
    } vec_t;

    vec_t vecs [8];

    load_store_ctrl dut (
        .CLK       (CLK),
        .RESET_N   (RESET_N),
        .req       (req),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .rdata     (rdata),
        .acc_count (acc_count),
        .Mem_Addr  (Mem_Addr),
        .Mem_rd    (Mem_rd),
        .Mem_wr    (Mem_wr),
        .Mem_DIN   (Mem_DIN),
        .Mem_DOUT  (Mem_DOUT)
    );

    load_store_ctrl #(.WordSize(32), .RD_WAIT(2), .WR_WAIT(3)) dut_b (
        .CLK       (CLK),
        .RESET_N   (rst_b),
        .req       (req_b),
        .wr        (wr),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy_b),
        .done      (done_b),
        .err       (err_b),
        .rdata     (rdata_b),
        .acc_count (acc_b),
        .Mem_Addr  (mem_addr_b),
        .Mem_rd    (mem_rd_b),
        .Mem_wr    (mem_wr_b),
        .Mem_DIN   (mem_din_b),
        .Mem_DOUT  (mem_dout_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    function automatic int word_index(input logic [31:0] a);
        return int'((a >> 2) & 32'h3F);
    endfunction

    // Memory models: preload a known pattern, then commit writes on negedge.
    always @(negedge CLK) begin
        if (mem_load) begin
            for (int i = 0; i < 64; i++) begin
                mem_a[i] <= 32'h1000_0000 + 32'(i);
                mem_b[i] <= 32'h2000_0000 + 32'(i);
            end
            mem_a[4] <= 32'hDEAD_BEEF;
            mem_b[4] <= 32'h0BAD_F00D;
        end else begin
            if (Mem_wr) begin
                mem_a[word_index(Mem_Addr)] <= Mem_DIN;
            end
            if (mem_wr_b) begin
                mem_b[word_index(mem_addr_b)] <= mem_din_b;
            end
        end
    end

    assign Mem_DOUT   = mem_a[word_index(Mem_Addr)];
    assign mem_dout_b = mem_b[word_index(mem_addr_b)];

    assign o_busy  = sel ? busy_b   : busy;
    assign o_done  = sel ? done_b   : done;
    assign o_err   = sel ? err_b    : err;
    assign o_rd    = sel ? mem_rd_b : Mem_rd;
    assign o_wr    = sel ? mem_wr_b : Mem_wr;
    assign o_rdata = sel ? rdata_b  : rdata;
    assign o_acc   = sel ? acc_b    : acc_count;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // One complete transaction: drive req for a single cycle at a negedge,
    // then watch every following negedge until done (bounded), tallying
    // the memory enables, and finally sample one cycle past done.
    task automatic applyStimulus(input logic s, input logic w,
                                 input logic [31:0] a, input logic [31:0] d);
        logic found;
        sel   = s;
        wr    = w;
        addr  = a;
        wdata = d;
        if (s) begin
            req_b = 1'b1;
        end else begin
            req = 1'b1;
        end
        @(negedge CLK);
        req       = 1'b0;
        req_b     = 1'b0;
        r_lat     = 0;
        r_err     = 1'b0;
        r_rdata   = '0;
        r_rd      = 0;
        r_wr      = 0;
        r_overlap = 0;
        found     = 1'b0;
        for (int i = 1; i <= 30 && !found; i++) begin
            if (o_rd) r_rd++;
            if (o_wr) r_wr++;
            if (o_rd && o_wr) r_overlap++;
            if (o_done) begin
                found   = 1'b1;
                r_lat   = i;
                r_err   = o_err;
                r_rdata = o_rdata;
            end else begin
                @(negedge CLK);
            end
        end
        if (!found) begin
            $display("[TB] transaction timed out waiting for done");
        end
        @(negedge CLK);
        r_done_after = o_done;
        r_busy_after = o_busy;
        r_acc        = o_acc;
    endtask

    initial begin
        logic [5:0] rd_pat;
        logic [5:0] done_pat;
        logic       saw_done;

        total    = 0;
        bad      = 0;
        sel      = 1'b0;
        req      = 1'b0;
        req_b    = 1'b0;
        wr       = 1'b0;
        addr     = '0;
        wdata    = '0;
        RESET_N  = 1'b0;
        rst_b    = 1'b0;
        mem_load = 1'b1;

        //          w     addr          wdata          err   rdata          lat rd wr acc
        vecs[0] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF, 3, 2, 0, 16'd1};
        vecs[1] = '{1'b1, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'hDEAD_BEEF, 2, 0, 1, 16'd2};
        vecs[2] = '{1'b1, 32'h0000_0006, 32'hFFFF_FFFF, 1'b1, 32'hDEAD_BEEF, 1, 0, 0, 16'd2};
        vecs[3] = '{1'b0, 32'h0000_0008, 32'h0,         1'b0, 32'h1234_5678, 3, 2, 0, 16'd3};
        vecs[4] = '{1'b0, 32'h0000_0001, 32'h0,         1'b1, 32'h1234_5678, 1, 0, 0, 16'd3};
        vecs[5] = '{1'b1, 32'h0000_0020, 32'hA5A5_5A5A, 1'b0, 32'h1234_5678, 2, 0, 1, 16'd4};
        vecs[6] = '{1'b0, 32'h0000_0020, 32'h0,         1'b0, 32'hA5A5_5A5A, 3, 2, 0, 16'd5};
        vecs[7] = '{1'b0, 32'h0000_002C, 32'h0,         1'b0, 32'h1000_000B, 3, 2, 0, 16'd6};

        repeat (2) @(negedge CLK);
        checkOutput("rst_busy",  32'(busy),      32'd0);
        checkOutput("rst_done",  32'(done),      32'd0);
        checkOutput("rst_err",   32'(err),       32'd0);
        checkOutput("rst_rd",    32'(Mem_rd),    32'd0);
        checkOutput("rst_wr",    32'(Mem_wr),    32'd0);
        checkOutput("rst_rdata", rdata,          32'd0);
        checkOutput("rst_acc",   32'(acc_count), 32'd0);
        checkOutput("rst_maddr", Mem_Addr,       32'd0);
        checkOutput("rst_mdin",  Mem_DIN,        32'd0);

        mem_load = 1'b0;
        RESET_N  = 1'b1;

        // Table of single transactions; the first one starts on the very
        // first posedge after reset release.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, vecs[i].w, vecs[i].a, vecs[i].d);
            checkOutput($sformatf("v%0d_lat", i),     32'(r_lat),        32'(vecs[i].e_lat));
            checkOutput($sformatf("v%0d_err", i),     32'(r_err),        32'(vecs[i].e_err));
            checkOutput($sformatf("v%0d_rdata", i),   r_rdata,           vecs[i].e_rdata);
            checkOutput($sformatf("v%0d_rdcyc", i),   32'(r_rd),         32'(vecs[i].e_rd));
            checkOutput($sformatf("v%0d_wrcyc", i),   32'(r_wr),         32'(vecs[i].e_wr));
            checkOutput($sformatf("v%0d_overlap", i), 32'(r_overlap),    32'd0);
            checkOutput($sformatf("v%0d_donepw", i),  32'(r_done_after), 32'd0);
            checkOutput($sformatf("v%0d_idle", i),    32'(r_busy_after), 32'd0);
            checkOutput($sformatf("v%0d_acc", i),     32'(r_acc),        32'(vecs[i].e_acc));
            if (vecs[i].w && !vecs[i].e_err) begin
                checkOutput($sformatf("v%0d_mem", i), mem_a[word_index(vecs[i].a)], vecs[i].d);
            end
        end
        checkOutput("misaligned_store_mem", mem_a[1], 32'h1000_0001);

        // req held high through a load: the second access must not start
        // until the controller is back in IDLE after done.
        sel  = 1'b0;
        wr   = 1'b0;
        addr = 32'h0000_0010;
        req  = 1'b1;
        rd_pat   = '0;
        done_pat = '0;
        for (int k = 0; k < 6; k++) begin
            @(negedge CLK);
            rd_pat[k]   = Mem_rd;
            done_pat[k] = done;
        end
        req = 1'b0;
        checkOutput("hold_rd_pattern",   32'(rd_pat),   32'b110011);
        checkOutput("hold_done_pattern", 32'(done_pat), 32'b000100);
        @(negedge CLK);
        checkOutput("hold_second_done",  32'(done),     32'd1);
        checkOutput("hold_second_rdata", rdata,         32'hDEAD_BEEF);
        @(negedge CLK);
        checkOutput("hold_acc",          32'(acc_count), 32'd8);

        // Counter wrap: preset the count to all ones, then complete one load.
        force dut.acc_count_q = 16'hFFFF;
        @(negedge CLK);
        release dut.acc_count_q;
        applyStimulus(1'b0, 1'b0, 32'h0000_0008, 32'h0);
        checkOutput("wrap_acc",   32'(r_acc),  32'd0);
        checkOutput("wrap_rdata", r_rdata,     32'h1234_5678);
        checkOutput("wrap_err",   32'(r_err),  32'd0);

        // Abort a WR_WAIT=3 store with reset, then a fresh load must work.
        rst_b = 1'b1;
        @(negedge CLK);
        sel   = 1'b1;
        wr    = 1'b1;
        addr  = 32'h0000_000C;
        wdata = 32'hCAFE_F00D;
        req_b = 1'b1;
        @(negedge CLK);
        req_b = 1'b0;
        checkOutput("abort_wr_active0", 32'(mem_wr_b), 32'd1);
        @(negedge CLK);
        checkOutput("abort_wr_active1", 32'(mem_wr_b), 32'd1);
        #2;
        rst_b = 1'b0;
        #1;
        checkOutput("abort_wr_drop",   32'(mem_wr_b), 32'd0);
        checkOutput("abort_busy_drop", 32'(busy_b),   32'd0);
        saw_done = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            if (done_b) saw_done = 1'b1;
        end
        rst_b = 1'b1;
        repeat (3) begin
            @(negedge CLK);
            if (done_b) saw_done = 1'b1;
        end
        checkOutput("abort_no_done", 32'(saw_done), 32'd0);
        checkOutput("abort_acc",     32'(acc_b),    32'd0);
        checkOutput("abort_rdata",   rdata_b,       32'd0);
        applyStimulus(1'b1, 1'b0, 32'h0000_0010, 32'h0);
        checkOutput("after_abort_lat",   32'(r_lat),  32'd3);
        checkOutput("after_abort_rdata", r_rdata,     32'h0BAD_F00D);
        checkOutput("after_abort_err",   32'(r_err),  32'd0);
        checkOutput("after_abort_acc",   32'(r_acc),  32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
